// File: rtl/vic_addr_gen.sv
// VIC address generator: builds the 14-bit address of every c/g/p/s/refresh access
// and owns VC/VCBASE, RC, the display/idle flag and the DRAM refresh counter.
module vic_addr_gen #(
    parameter int NUM_SPRITES = 8
) (
    input  logic                           clk_dot4x,
    input  logic                           rst,
    input  logic                           phi_phase_start_addr,
    input  logic [3:0]                     cycle_type,
    input  logic [6:0]                     cycle_num,
    input  logic [8:0]                     raster_line,
    input  logic                           badline,
    input  logic [3:0]                     vm,
    input  logic [2:0]                     cb,
    input  logic                           bmm,
    input  logic                           ecm,
    input  logic [7:0]                     char_ptr,
    input  logic [$clog2(NUM_SPRITES)-1:0] sprite_cnt,
    input  logic [NUM_SPRITES*8-1:0]       sprite_ptr_i,
    input  logic [NUM_SPRITES*6-1:0]       sprite_mc_i,
    output logic [13:0]                    ado,
    output logic                           idle,
    output logic [9:0]                     vc,
    output logic [2:0]                     rc
);

    // Half-cycle codes decoded here; HRX, HGI and the idle codes fall to the default.
    localparam logic [3:0] VIC_LP  = 4'h0;
    localparam logic [3:0] VIC_LS2 = 4'h1;
    localparam logic [3:0] VIC_HS1 = 4'h2;
    localparam logic [3:0] VIC_HS3 = 4'h3;
    localparam logic [3:0] VIC_LR  = 4'h4;
    localparam logic [3:0] VIC_LG  = 4'h5;
    localparam logic [3:0] VIC_HRC = 4'h6;
    localparam logic [3:0] VIC_HGC = 4'h7;

    logic [NUM_SPRITES-1:0][7:0] ptr_arr;
    logic [NUM_SPRITES-1:0][5:0] mc_arr;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
        assign ptr_arr[g] = sprite_ptr_i[(NUM_SPRITES-1-g)*8 +: 8];
        assign mc_arr[g]  = sprite_mc_i[(NUM_SPRITES-1-g)*6 +: 6];
    end

    logic [13:0] ado_q, ado_d;
    logic        idle_q, idle_d;
    logic [9:0]  vc_q, vc_d;
    logic [9:0]  vcbase_q, vcbase_d;
    logic [2:0]  rc_q, rc_d;
    logic [7:0]  refc_q, refc_d;
    logic [6:0]  last_cyc_q, last_cyc_d;
    logic        first_q, first_d;
    logic        line_ev;
    logic [13:0] g_addr;

    always_comb begin
        g_addr = 14'h3FFF;
        if (!idle_q) begin
            if (bmm) g_addr = {cb[2], vc_q, rc_q};
            else     g_addr = {cb, char_ptr, rc_q};
        end
        if (ecm) g_addr[10:9] = 2'b00;
    end

    always_comb begin
        ado_d      = ado_q;
        idle_d     = idle_q;
        vc_d       = vc_q;
        vcbase_d   = vcbase_q;
        rc_d       = rc_q;
        refc_d     = refc_q;
        last_cyc_d = last_cyc_q;
        first_d    = first_q;
        line_ev    = 1'b0;
        if (phi_phase_start_addr) begin
            // first_q makes the first strobe after reset count as a new cycle
            line_ev    = (cycle_type == VIC_LR) || first_q || (cycle_num != last_cyc_q);
            last_cyc_d = cycle_num;
            first_d    = 1'b0;
            case (cycle_type)
                VIC_LR: begin
                    ado_d  = {6'b111111, refc_q};
                    refc_d = refc_q - 8'd1;
                end
                VIC_HRC, VIC_HGC: ado_d = {vm, vc_q};
                VIC_LG: begin
                    ado_d = g_addr;
                    if (!idle_q) vc_d = vc_q + 10'd1;
                end
                VIC_LP: ado_d = {vm, 7'h7F, 3'(sprite_cnt)};
                VIC_LS2, VIC_HS1, VIC_HS3: ado_d = {ptr_arr[sprite_cnt], mc_arr[sprite_cnt]};
                default: ado_d = 14'h3FFF;
            endcase
            if (line_ev) begin
                if (raster_line == 9'd0 && cycle_num == 7'd0) begin
                    vcbase_d = '0;
                    refc_d   = 8'hFF;
                end
                if (cycle_num == 7'd13) begin
                    vc_d = vcbase_q;
                    if (badline) rc_d = '0;
                end
                if (badline) idle_d = 1'b0;
                if (cycle_num == 7'd57) begin
                    if (rc_q == 3'd7) begin
                        vcbase_d = vc_q;
                        if (!badline) idle_d = 1'b1;
                    end
                    // rc advances on the pre-update display state
                    if (!idle_q || badline) rc_d = rc_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            ado_q      <= 14'h3FFF;
            idle_q     <= 1'b1;
            vc_q       <= '0;
            vcbase_q   <= '0;
            rc_q       <= '0;
            refc_q     <= 8'hFF;
            last_cyc_q <= '0;
            first_q    <= 1'b1;
        end else begin
            ado_q      <= ado_d;
            idle_q     <= idle_d;
            vc_q       <= vc_d;
            vcbase_q   <= vcbase_d;
            rc_q       <= rc_d;
            refc_q     <= refc_d;
            last_cyc_q <= last_cyc_d;
            first_q    <= first_d;
        end
    end

    assign ado  = ado_q;
    assign idle = idle_q;
    assign vc   = vc_q;
    assign rc   = rc_q;

endmodule

// File: tb/tb_vic_addr_gen.sv
// Directed bench for vic_addr_gen: stimulus pushes expected results, a monitor pops
// and compares them one clock after each address strobe.
module tb_vic_addr_gen;

    localparam logic [3:0] CT_LP  = 4'h0;
    localparam logic [3:0] CT_LS2 = 4'h1;
    localparam logic [3:0] CT_HS1 = 4'h2;
    localparam logic [3:0] CT_HS3 = 4'h3;
    localparam logic [3:0] CT_LR  = 4'h4;
    localparam logic [3:0] CT_LG  = 4'h5;
    localparam logic [3:0] CT_HGC = 4'h7;
    localparam logic [3:0] CT_IDL = 4'hF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        phi = 1'b0;
    logic [3:0]  cycle_type = CT_IDL;
    logic [6:0]  cycle_num = '0;
    logic [8:0]  raster_line = 9'd5;
    logic        badline = 1'b0;
    logic [3:0]  vm = '0;
    logic [2:0]  cb = '0;
    logic        bmm = 1'b0;
    logic        ecm = 1'b0;
    logic [7:0]  char_ptr = '0;
    logic [2:0]  sprite_cnt = '0;
    logic [63:0] sprite_ptr = {8'h12, 8'h11, 8'h80, 8'h33, 8'h33, 8'h33, 8'h33, 8'h55};
    logic [47:0] sprite_mc  = {6'h01, 6'h05, 6'h3E, 6'h0A, 6'h0A, 6'h0A, 6'h0A, 6'h2A};
    logic [13:0] ado;
    logic        idle;
    logic [9:0]  vc;
    logic [2:0]  rc;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [13:0] ado;
        logic        idle;
        logic [9:0]  vc;
        logic [2:0]  rc;
        string       nm;
    } exp_t;
    exp_t sb[$];

    vic_addr_gen #(.NUM_SPRITES(8)) dut (
        .clk_dot4x(clk), .rst(rst), .phi_phase_start_addr(phi),
        .cycle_type(cycle_type), .cycle_num(cycle_num), .raster_line(raster_line),
        .badline(badline), .vm(vm), .cb(cb), .bmm(bmm), .ecm(ecm),
        .char_ptr(char_ptr), .sprite_cnt(sprite_cnt),
        .sprite_ptr_i(sprite_ptr), .sprite_mc_i(sprite_mc),
        .ado(ado), .idle(idle), .vc(vc), .rc(rc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic strobe(input logic [3:0] ct, input logic [6:0] cn, input logic [13:0] a,
                          input logic i, input logic [9:0] v, input logic [2:0] r, input string nm);
        exp_t e;
        e.ado = a; e.idle = i; e.vc = v; e.rc = r; e.nm = nm;
        @(negedge clk);
        cycle_type = ct;
        cycle_num  = cn;
        phi        = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        phi = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (phi === 1'b1 && rst === 1'b0) begin
                #1;
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({e.nm, ".ado"},  32'(ado),  32'(e.ado));
                    chk({e.nm, ".idle"}, 32'(idle), 32'(e.idle));
                    chk({e.nm, ".vc"},   32'(vc),   32'(e.vc));
                    chk({e.nm, ".rc"},   32'(rc),   32'(e.rc));
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset.ado", 32'(ado), 32'h3FFF);
        chk("reset.idle", 32'(idle), 32'd1);
        chk("reset.vc", 32'(vc), 32'd0);
        chk("reset.rc", 32'(rc), 32'd0);
        rst = 1'b0;

        // idle g-access, plain and with ecm
        strobe(CT_LG, 7'd20, 14'h3FFF, 1'b1, 10'd0, 3'd0, "lg_idle");
        ecm = 1'b1;
        strobe(CT_LG, 7'd21, 14'h39FF, 1'b1, 10'd0, 3'd0, "lg_idle_ecm");
        ecm = 1'b0;

        // badline at cycle 13 enters display; c-access uses VC
        raster_line = 9'h033; badline = 1'b1; vm = 4'd1;
        strobe(CT_IDL, 7'd13, 14'h3FFF, 1'b0, 10'd0, 3'd0, "bad_c13");
        strobe(CT_HGC, 7'd13, 14'h0400, 1'b0, 10'd0, 3'd0, "c_access0");
        for (int i = 0; i < 40; i++) begin
            char_ptr = 8'(i);
            strobe(CT_LG, 7'(14 + i), 14'(i << 3), 1'b0, 10'(i + 1), 3'd0, "lg_run");
        end
        strobe(CT_HGC, 7'd54, 14'h0428, 1'b0, 10'd40, 3'd0, "c_access40");

        // raise rc to 3 via cycle 57 with badline
        for (int k = 0; k < 3; k++) begin
            strobe(CT_IDL, 7'd57, 14'h3FFF, 1'b0, 10'd40, 3'(k + 1), "rc_inc57");
            strobe(CT_IDL, 7'd58, 14'h3FFF, 1'b0, 10'd40, 3'(k + 1), "rc_hold58");
        end
        cb = 3'd2; char_ptr = 8'h41;
        strobe(CT_LG, 7'd59, 14'h120B, 1'b0, 10'd41, 3'd3, "text_mode");

        // reload vc from vcbase without badline, then bitmap mode
        badline = 1'b0; bmm = 1'b1; cb = 3'd4;
        strobe(CT_IDL, 7'd13, 14'h3FFF, 1'b0, 10'd0, 3'd3, "vc_reload");
        for (int v = 0; v < 6; v++)
            strobe(CT_LG, 7'(14 + v), 14'h2000 | 14'(v << 3) | 14'd3, 1'b0, 10'(v + 1), 3'd3, "bitmap");
        bmm = 1'b0; ecm = 1'b1; cb = 3'd7; char_ptr = 8'hFF;
        strobe(CT_LG, 7'd20, 14'h39FB, 1'b0, 10'd7, 3'd3, "text_ecm");
        ecm = 1'b0;

        // p- and s-accesses
        sprite_cnt = 3'd5;
        strobe(CT_LP, 7'd21, 14'h07FD, 1'b0, 10'd7, 3'd3, "p_access");
        sprite_cnt = 3'd2;
        strobe(CT_LS2, 7'd22, 14'h203E, 1'b0, 10'd7, 3'd3, "s_ls2");
        sprite_cnt = 3'd0;
        strobe(CT_HS1, 7'd22, 14'h0481, 1'b0, 10'd7, 3'd3, "s_hs1");
        sprite_cnt = 3'd7;
        strobe(CT_HS3, 7'd22, 14'h156A, 1'b0, 10'd7, 3'd3, "s_hs3");

        // rc==7 at cycle 57 without badline: latch vcbase, go idle
        for (int k = 0; k < 4; k++) begin
            strobe(CT_IDL, 7'd57, 14'h3FFF, 1'b0, 10'd7, 3'(4 + k), "rc_up57");
            strobe(CT_IDL, 7'd58, 14'h3FFF, 1'b0, 10'd7, 3'(4 + k), "rc_up58");
        end
        strobe(CT_IDL, 7'd57, 14'h3FFF, 1'b1, 10'd7, 3'd0, "rc7_nobad");

        // vcbase now 7: prove it by moving vc then reloading at cycle 13
        badline = 1'b1; cb = 3'd2; char_ptr = 8'h41;
        strobe(CT_IDL, 7'd13, 14'h3FFF, 1'b0, 10'd7, 3'd0, "vcbase_load");
        strobe(CT_LG, 7'd14, 14'h1208, 1'b0, 10'd8, 3'd0, "lg_after_load");
        strobe(CT_LG, 7'd15, 14'h1208, 1'b0, 10'd9, 3'd0, "lg_after_load");
        strobe(CT_IDL, 7'd13, 14'h3FFF, 1'b0, 10'd7, 3'd0, "vcbase_reload");

        // rc==7 at cycle 57 with badline: stay in display
        for (int k = 0; k < 7; k++) begin
            strobe(CT_IDL, 7'd57, 14'h3FFF, 1'b0, 10'd7, 3'(k + 1), "rcb_up57");
            strobe(CT_IDL, 7'd58, 14'h3FFF, 1'b0, 10'd7, 3'(k + 1), "rcb_up58");
        end
        strobe(CT_IDL, 7'd57, 14'h3FFF, 1'b0, 10'd7, 3'd0, "rc7_bad");

        // refresh on line 0
        badline = 1'b0; raster_line = 9'd0;
        strobe(CT_LR, 7'd0, 14'h3FFF, 1'b0, 10'd7, 3'd0, "refresh_line0");
        for (int k = 1; k <= 6; k++)
            strobe(CT_LR, 7'(k), 14'h3FFF - 14'(k - 1), 1'b0, 10'd7, 3'd0, "refresh");
        strobe(CT_IDL, 7'd13, 14'h3FFF, 1'b0, 10'd0, 3'd0, "vcbase_line0");
        strobe(CT_LR, 7'd0, 14'h3FF9, 1'b0, 10'd0, 3'd0, "refresh_collide");

        // no strobe: state holds even with LR on the bus
        @(negedge clk);
        cycle_type = CT_LR;
        repeat (3) @(negedge clk);
        chk("hold.ado", 32'(ado), 32'h3FF9);
        strobe(CT_LR, 7'd1, 14'h3FFF, 1'b0, 10'd0, 3'd0, "refc_restored");
        strobe(CT_LG, 7'd2, 14'h1208, 1'b0, 10'd1, 3'd0, "pre_reset_lg");

        // mid-line reset while a strobe is asserted
        @(negedge clk);
        rst = 1'b1; phi = 1'b1; cycle_type = CT_LR; cycle_num = 7'd3;
        @(negedge clk);
        rst = 1'b0; phi = 1'b0;
        chk("midrst.ado", 32'(ado), 32'h3FFF);
        chk("midrst.idle", 32'(idle), 32'd1);
        chk("midrst.vc", 32'(vc), 32'd0);
        chk("midrst.rc", 32'(rc), 32'd0);
        raster_line = 9'd5;
        strobe(CT_LR, 7'd20, 14'h3FFF, 1'b1, 10'd0, 3'd0, "refc_after_rst");
        strobe(CT_LG, 7'd21, 14'h3FFF, 1'b1, 10'd0, 3'd0, "lg_after_rst");

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
